// File: rtl/student_dmux8way16_buf.sv
`default_nettype none
// ============================================================================
// Module   : student_dmux8way16_buf
// Brief    : Registered 8-way demux with one holding register per channel,
//            valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module student_dmux8way16_buf #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic [3:0]         occupancy
);

  localparam int C_NCH = 8;

  logic [C_NCH-1:0] r_full;
  logic [WIDTH-1:0] r_data [C_NCH];
  logic [3:0]       r_occ;

  logic             w_accept;
  logic [C_NCH-1:0] w_load;
  logic [C_NCH-1:0] w_drain;
  logic [C_NCH-1:0] w_full_next;
  logic [3:0]       w_cnt;

  // A draining target frees its slot in the same cycle, so ready ignores in_valid.
  assign in_ready    = ~r_full[in_sel] | out_ready[in_sel];
  assign w_accept    = in_valid & in_ready;
  assign w_drain     = r_full & out_ready;
  assign w_full_next = (r_full & ~w_drain) | w_load;

  always_comb begin
    w_load = '0;
    w_load[in_sel] = w_accept;
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < C_NCH; i++) begin
      w_cnt = w_cnt + {3'b000, w_full_next[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= '0;
      r_occ  <= '0;
      for (int i = 0; i < C_NCH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_full <= w_full_next;
      r_occ  <= w_cnt;
      for (int i = 0; i < C_NCH; i++) begin
        if (w_load[i]) begin
          r_data[i] <= in_data;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < C_NCH; g++) begin : g_out
      assign out_data[WIDTH*g +: WIDTH] = r_data[g];
    end
  endgenerate

  assign out_valid = r_full;
  assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_student_dmux8way16_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_student_dmux8way16_buf
// Brief    : Self-checking bench: behavioural channel model plus directed cases.
// Revision : 1.0
// ============================================================================
module tb_student_dmux8way16_buf;

  localparam int WIDTH = 16;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [2:0]         in_sel;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [8*WIDTH-1:0] out_data;
  logic [3:0]         occupancy;

  int n_pass;
  int n_total;

  // Model: what each channel holds, plus delivery counters.
  bit         m_full [8];
  logic [15:0] m_data [8];
  int         m_drained;
  int         dut_drained;

  student_dmux8way16_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += m_full[i] ? 1 : 0;
    return c;
  endfunction

  function automatic int dut_pop();
    int c = 0;
    for (int i = 0; i < 8; i++) c += out_valid[i] ? 1 : 0;
    return c;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = 16'h0000;
      end
    end else begin
      int  tgt;
      bit  acc;
      tgt = int'(in_sel);
      acc = in_valid && (!m_full[tgt] || out_ready[tgt]);
      for (int i = 0; i < 8; i++) begin
        if (out_valid[i] && out_ready[i]) dut_drained++;
        if (m_full[i] && out_ready[i]) begin
          m_full[i] = 1'b0;
          m_drained++;
        end
      end
      if (acc) begin
        m_full[tgt] = 1'b1;
        m_data[tgt] = in_data;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] ev;
    logic       er;
    for (int i = 0; i < 8; i++) ev[i] = m_full[i];
    er = !m_full[int'(in_sel)] || out_ready[in_sel];
    check("out_valid", {24'h0, out_valid}, {24'h0, ev});
    check("occupancy", {28'h0, occupancy}, model_count());
    check("occ_vs_pop", {28'h0, occupancy}, dut_pop());
    check("in_ready", {31'h0, in_ready}, {31'h0, er});
    for (int i = 0; i < 8; i++) begin
      check("out_data", {16'h0, out_data[16*i +: 16]}, {16'h0, m_data[i]});
    end
  end

  task automatic step(input logic v, input logic [2:0] s, input logic [15:0] d, input logic [7:0] r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    n_pass = 0; n_total = 0; m_drained = 0; dut_drained = 0;
    reset = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = '0; out_ready = '0;
    #12;
    check("rst_valid", {24'h0, out_valid}, 32'h00);
    check("rst_occ", {28'h0, occupancy}, 32'h0);
    reset = 1'b0;

    // Load a channel, then assert reset mid-cycle with a live request.
    step(1'b1, 3'd1, 16'h0101, 8'h00);
    step(1'b1, 3'd3, 16'hBEEF, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", {24'h0, out_valid}, 32'h00);
    check("midrst_occ", {28'h0, occupancy}, 32'h0);
    check("midrst_data", out_data[31:0], 32'h0);
    check("midrst_data_hi", out_data[127:96], 32'h0);
    #4;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_ready", {31'h0, in_ready}, 32'h1);

    // Single write to channel 5, then a blocked second write.
    step(1'b1, 3'd5, 16'h1234, 8'h00);
    step(1'b1, 3'd5, 16'h9999, 8'h00);
    @(negedge clk);
    check("w5_valid", {24'h0, out_valid}, 32'h20);
    check("w5_slice", {16'h0, out_data[80 +: 16]}, 32'h1234);
    check("w5_occ", {28'h0, occupancy}, 32'h1);
    check("w5_blocked", {31'h0, in_ready}, 32'h0);
    step(1'b0, 3'd0, 16'h0000, 8'h00);
    @(negedge clk);
    check("w5_kept", {16'h0, out_data[80 +: 16]}, 32'h1234);
    step(1'b0, 3'd0, 16'h0000, 8'h20);

    // Fill every channel.
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'(i), 8'h00);
    step(1'b0, 3'd0, 16'h0000, 8'h00);
    @(negedge clk);
    check("fill_valid", {24'h0, out_valid}, 32'hFF);
    check("fill_occ", {28'h0, occupancy}, 32'h8);
    check("fill_slice7", {16'h0, out_data[112 +: 16]}, 32'h0007);
    step(1'b1, 3'd0, 16'hDEAD, 8'h00);
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1;
      check("full_ready", {31'h0, in_ready}, 32'h0);
    end
    step(1'b0, 3'd0, 16'h0000, 8'hFF);

    // Pass-through on channel 2.
    step(1'b1, 3'd2, 16'hAAAA, 8'h00);
    step(1'b1, 3'd2, 16'h5555, 8'h04);
    @(negedge clk);
    check("pt_ready", {31'h0, in_ready}, 32'h1);
    step(1'b0, 3'd0, 16'h0000, 8'h00);
    @(negedge clk);
    check("pt_valid2", {31'h0, out_valid[2]}, 32'h1);
    check("pt_slice2", {16'h0, out_data[32 +: 16]}, 32'h5555);
    check("pt_occ", {28'h0, occupancy}, 32'h1);
    step(1'b0, 3'd0, 16'h0000, 8'h04);

    // Multi-drain of channels 0, 4, 7.
    step(1'b1, 3'd0, 16'h1000, 8'h00);
    step(1'b1, 3'd4, 16'h4000, 8'h00);
    step(1'b1, 3'd7, 16'h7000, 8'h00);
    step(1'b0, 3'd5, 16'h0000, 8'h91);
    step(1'b0, 3'd5, 16'h0000, 8'h00);
    @(negedge clk);
    check("md_valid", {24'h0, out_valid}, 32'h00);
    check("md_occ", {28'h0, occupancy}, 32'h0);
    check("md_slice0", {16'h0, out_data[0 +: 16]}, 32'h1000);
    check("md_slice4", {16'h0, out_data[64 +: 16]}, 32'h4000);
    check("md_slice7", {16'h0, out_data[112 +: 16]}, 32'h7000);

    // Random stress; the per-cycle compare process does the checking.
    for (int c = 0; c < 2000; c++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           16'($urandom), 8'($urandom));
    end
    step(1'b0, 3'd0, 16'h0000, 8'hFF);
    step(1'b0, 3'd0, 16'h0000, 8'h00);
    @(negedge clk);
    check("drain_count", dut_drained, m_drained);
    check("final_occ", {28'h0, occupancy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
